multi_pulse_gen: RTL and testbench
==================================

// Module: multi_pulse_gen
// PURPOSE
//  Synthesizable N-channel clocked pulse generator: successor to the fixed-parameter pulse_gen stimulus primitive.
//  Per-channel run-time delay/width/period/count/mode/idle-level, written through a shared config port.
//  Drives neuron-array stimulus (spike trains, enables) in sim and on silicon; probes observe pulse_out/busy/done.
// PARAMETERS
//  NUM_CH   4   number of independent channels (>=1)
//  CNT_W    16  width of delay/width/period fields, in clk cycles
//  NUM_W    8   width of burst pulse-count field
// PORTS
//  clk         in   1                   clock, rising edge
//  rst         in   1                   asynchronous reset, active-high
//  cfg_we      in   1                   write config of channel cfg_ch
//  cfg_ch      in   max(1,$clog2(NUM_CH)) target channel; values >=NUM_CH ignored
//  cfg_delay   in   CNT_W               cycles from start to first rising edge (0 allowed)
//  cfg_width   in   CNT_W               active cycles per pulse
//  cfg_period  in   CNT_W               cycles from one pulse start to the next
//  cfg_count   in   NUM_W               pulses per burst (mode BURST)
//  cfg_mode    in   2                   0 SINGLE, 1 BURST, 2 CONT, 3 = SINGLE
//  cfg_init    in   1                   idle level (pulse_out = init when inactive, ~init when active)
//  start       in   NUM_CH              per-channel start request, sampled each edge
//  stop        in   NUM_CH              per-channel abort request
//  pulse_out   out  NUM_CH              registered pulse output
//  busy        out  NUM_CH              channel not IDLE
//  done        out  NUM_CH              1-cycle strobe: channel returned to IDLE
// BEHAVIOUR
//  Reset: pulse_out=0, busy=0, done=0, all FSMs IDLE; config regs delay=0 width=1 period=2 count=1 mode=0 init=0.
//  Config: cfg_we writes channel's shadow regs at the edge; running channel unaffected (uses snapshot taken at start).
//  start & cfg_we same channel same edge: snapshot takes pre-write values.
//  Per-channel FSM IDLE -> DELAY -> HIGH <-> LOW -> IDLE; all outputs registered.
//   IDLE: start[i] at edge k -> snapshot; D=0 -> HIGH, else DELAY; pulse_out active from edge k+1+D.
//   DELAY: D cycles, then HIGH.  HIGH: W cycles active.  LOW: L=max(P-W,1) cycles at idle level.
//   Pulse n rises at edge k+1+D+n*(W+L); with P>W this equals k+1+D+n*P.
//   SINGLE: one pulse; BURST: count pulses (count=0 treated as 1); CONT: repeats until stop.
//   Finish: at the edge ending last HIGH -> IDLE, pulse_out=init, busy=0, done=1 for one cycle (no trailing LOW).
//  W=0: no active cycles; channel goes IDLE with done one cycle after start (D ignored).
//  stop[i]: any non-IDLE state -> IDLE next edge, pulse_out=init, done=1; stop in IDLE: no effect, no done.
//  start & stop same edge: stop wins (IDLE channel stays IDLE, no done).
//  start while busy: ignored.  Channels fully independent; counters never wrap (saturate at load values).
//  rst mid-operation: immediate return to reset state, pending done discarded.
// CONFIGURATION
//  MULTI_PULSE_GEN_PCNT_EN defined: adds output pulse_cnt [NUM_CH*NUM_W] = per-channel count of rising edges
//   since start (cleared at start and rst, saturates at 2^NUM_W-1, held after done).
//  Not defined: port and counters absent; all other behaviour identical.
// TESTING
//  rst pulse mid-CONT -> all outputs 0 same cycle (async), IDLE after release.
//  ch0 SINGLE D=3 W=2 init=0, start@edge k -> pulse_out[0]=1 edges k+4..k+5, done[0] at k+6, busy k+1..k+5.
//  ch1 BURST count=3 D=0 W=1 P=4 -> rises at k+1,k+5,k+9; done at k+10; pulse_cnt=3 if PCNT_EN.
//  ch2 CONT W=2 P=5 init=1, stop after 12 cycles -> low-going pulses period 5, idle 1 and done next edge.
//  W=5 P=3 -> L=1, period 6; W=0 -> no pulse, done at k+1; start+stop same edge -> nothing.
//  cfg_we to ch0 during run and start+cfg_we same edge -> running/started pulse uses old values; next start uses new.

Source files
------------

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen: N-channel run-time configurable pulse generator (single, burst, continuous)
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cfg_we, cfg_ch    write strobe and target channel for the shadow config (channels >= NUM_CH ignored)
//   cfg_delay/width/period/count/mode/init  shadow config values written at the edge
//   start, stop       per-channel start and abort requests (stop wins over start)
//   pulse_out         registered pulse output, idle level = init, active level = ~init
//   busy, done        channel not idle; one-cycle strobe when a channel returns to idle
//   pulse_cnt         per-channel rising-edge count since start, present only with MULTI_PULSE_GEN_PCNT_EN
module multi_pulse_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int NUM_W  = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [NUM_W-1:0]  cfg_count,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_init,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
`ifdef MULTI_PULSE_GEN_PCNT_EN
    output logic [NUM_CH*NUM_W-1:0] pulse_cnt,
`endif
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] delay_q, delay_d, width_q, width_d, period_q, period_d;
        logic [NUM_W-1:0] count_q, count_d;
        logic [1:0]       mode_q, mode_d;
        logic             init_q, init_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, s_width_q, s_width_d, s_low_q, s_low_d;
        logic [NUM_W-1:0] rem_q, rem_d;
        logic             s_cont_q, s_cont_d, s_init_q, s_init_d;
        logic             pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;
        logic             wr, go, last;

        assign wr   = cfg_we && (int'(cfg_ch) == i);
        assign go   = start[i] && !stop[i] && (state_q == IDLE);
        // rem_q counts the pulse in progress, so the last one is at 1; CONT never ends on its own
        assign last = !s_cont_q && (rem_q == NUM_W'(1));

        always_comb begin
            delay_d   = wr ? cfg_delay  : delay_q;
            width_d   = wr ? cfg_width  : width_q;
            period_d  = wr ? cfg_period : period_q;
            count_d   = wr ? cfg_count  : count_q;
            mode_d    = wr ? cfg_mode   : mode_q;
            init_d    = wr ? cfg_init   : init_q;
            state_d   = state_q;
            cnt_d     = cnt_q;
            rem_d     = rem_q;
            s_width_d = s_width_q;
            s_low_d   = s_low_q;
            s_cont_d  = s_cont_q;
            s_init_d  = s_init_q;
            done_d    = 1'b0;
            if (stop[i] && state_q != IDLE) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (go) begin
                        // snapshot reads the shadow regs before any same-edge write
                        s_width_d = width_q;
                        s_low_d   = (period_q > width_q) ? period_q - width_q : CNT_W'(1);
                        s_cont_d  = mode_q == 2'd2;
                        s_init_d  = init_q;
                        rem_d     = (mode_q == 2'd1 && count_q != '0) ? count_q : NUM_W'(1);
                        if (width_q == '0) begin
                            done_d = 1'b1;
                        end else if (delay_q == '0) begin
                            state_d = HIGH;
                            cnt_d   = width_q;
                        end else begin
                            state_d = DELAY;
                            cnt_d   = delay_q;
                        end
                    end
                    DELAY: begin
                        state_d = (cnt_q == CNT_W'(1)) ? HIGH : DELAY;
                        cnt_d   = (cnt_q == CNT_W'(1)) ? s_width_q : cnt_q - CNT_W'(1);
                    end
                    HIGH: if (cnt_q != CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOW;
                        cnt_d   = s_low_q;
                    end
                    LOW: if (cnt_q != CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = HIGH;
                        cnt_d   = s_width_q;
                        rem_d   = s_cont_q ? rem_q : rem_q - NUM_W'(1);
                    end
                    default: state_d = IDLE;
                endcase
            end
            busy_d  = state_d != IDLE;
            // a run uses its snapshot level; a channel sitting idle follows the shadow init
            pulse_d = (state_d == HIGH) ? ~s_init_d : (state_q == IDLE && !go) ? init_q : s_init_d;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                delay_q   <= '0;
                width_q   <= CNT_W'(1);
                period_q  <= CNT_W'(2);
                count_q   <= NUM_W'(1);
                mode_q    <= 2'd0;
                init_q    <= 1'b0;
                cnt_q     <= '0;
                rem_q     <= '0;
                s_width_q <= '0;
                s_low_q   <= '0;
                s_cont_q  <= 1'b0;
                s_init_q  <= 1'b0;
                pulse_q   <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                delay_q   <= delay_d;
                width_q   <= width_d;
                period_q  <= period_d;
                count_q   <= count_d;
                mode_q    <= mode_d;
                init_q    <= init_d;
                cnt_q     <= cnt_d;
                rem_q     <= rem_d;
                s_width_q <= s_width_d;
                s_low_q   <= s_low_d;
                s_cont_q  <= s_cont_d;
                s_init_q  <= s_init_d;
                pulse_q   <= pulse_d;
                busy_q    <= busy_d;
                done_q    <= done_d;
            end
        end

        assign pulse_out[i] = pulse_q;
        assign busy[i]      = busy_q;
        assign done[i]      = done_q;

`ifdef MULTI_PULSE_GEN_PCNT_EN
        logic [NUM_W-1:0] pcnt_q, pcnt_d, pcnt_base;
        logic             rise;

        assign rise      = (state_d == HIGH) && (state_q != HIGH);
        assign pcnt_base = go ? '0 : pcnt_q;
        assign pcnt_d    = (rise && pcnt_base != '1) ? pcnt_base + NUM_W'(1) : pcnt_base;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) pcnt_q <= '0;
            else     pcnt_q <= pcnt_d;
        end

        assign pulse_cnt[i*NUM_W +: NUM_W] = pcnt_q;
`endif
    end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb_multi_pulse_gen: directed, table-driven check of multi_pulse_gen (4 channels, 16-bit timers, 8-bit counts)
module tb_multi_pulse_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_delay = '0, cfg_width = '0, cfg_period = '0;
    logic [7:0]  cfg_count = '0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_init = 1'b0;
    logic [3:0]  start = '0, stop = '0;
    logic [3:0]  pulse_out, busy, done;
`ifdef MULTI_PULSE_GEN_PCNT_EN
    logic [31:0] pulse_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    multi_pulse_gen #(.NUM_CH(4), .CNT_W(16), .NUM_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
        .cfg_count(cfg_count), .cfg_mode(cfg_mode), .cfg_init(cfg_init),
        .start(start), .stop(stop),
`ifdef MULTI_PULSE_GEN_PCNT_EN
        .pulse_cnt(pulse_cnt),
`endif
        .pulse_out(pulse_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic [15:0] d, w, p;
        logic [7:0]  n;
        logic [1:0]  m;
        logic        ini;
        logic [3:0]  st, sp, ep, eb, ed;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t cy(input int st, sp, ep, eb, ed);
        vec_t v;
        v = '{we: 1'b0, ch: 2'd0, d: 16'd0, w: 16'd0, p: 16'd0, n: 8'd0, m: 2'd0, ini: 1'b0,
              st: 4'(st), sp: 4'(sp), ep: 4'(ep), eb: 4'(eb), ed: 4'(ed)};
        return v;
    endfunction

    function automatic vec_t cf(input int ch, d, w, p, n, m, ini, st, ep, eb, ed);
        vec_t v;
        v = '{we: 1'b1, ch: 2'(ch), d: 16'(d), w: 16'(w), p: 16'(p), n: 8'(n), m: 2'(m), ini: 1'(ini),
              st: 4'(st), sp: 4'd0, ep: 4'(ep), eb: 4'(eb), ed: 4'(ed)};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] ep, input logic [3:0] eb, input logic [3:0] ed);
        chk({nm, " pulse_out"}, 32'(pulse_out), 32'(ep));
        chk({nm, " busy"}, 32'(busy), 32'(eb));
        chk({nm, " done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        // ch0 SINGLE D=3 W=2
        tv.push_back(cf(0, 3, 2, 4, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(cy(1, 0, 0, 1, 0));
        tv.push_back(cy(0, 0, 0, 1, 0));
        tv.push_back(cy(0, 0, 0, 1, 0));
        tv.push_back(cy(0, 0, 1, 1, 0));
        tv.push_back(cy(0, 0, 1, 1, 0));
        tv.push_back(cy(0, 0, 0, 0, 1));
        tv.push_back(cy(0, 0, 0, 0, 0));
        // ch1 BURST count=3 D=0 W=1 P=4: rises 1, 5, 9, done 10
        tv.push_back(cf(1, 0, 1, 4, 3, 1, 0, 0, 0, 0, 0));
        tv.push_back(cy(2, 0, 2, 2, 0));
        for (int k = 0; k < 3; k++) tv.push_back(cy(0, 0, 0, 2, 0));
        tv.push_back(cy(0, 0, 2, 2, 0));
        for (int k = 0; k < 3; k++) tv.push_back(cy(0, 0, 0, 2, 0));
        tv.push_back(cy(0, 0, 2, 2, 0));
        tv.push_back(cy(0, 0, 0, 0, 2));
        tv.push_back(cy(0, 0, 0, 0, 0));
        // ch2 CONT W=2 P=5 init=1: low-going pulses every 5, then stop, then stop while idle
        tv.push_back(cf(2, 0, 2, 5, 0, 2, 1, 0, 0, 0, 0));
        tv.push_back(cy(4, 0, 0, 4, 0));
        tv.push_back(cy(0, 0, 0, 4, 0));
        for (int k = 0; k < 3; k++) tv.push_back(cy(0, 0, 4, 4, 0));
        tv.push_back(cy(0, 0, 0, 4, 0));
        tv.push_back(cy(0, 0, 0, 4, 0));
        for (int k = 0; k < 3; k++) tv.push_back(cy(0, 0, 4, 4, 0));
        tv.push_back(cy(0, 0, 0, 4, 0));
        tv.push_back(cy(0, 0, 0, 4, 0));
        tv.push_back(cy(0, 4, 4, 0, 4));
        tv.push_back(cy(0, 0, 4, 0, 0));
        tv.push_back(cy(0, 4, 4, 0, 0));
        // ch3 BURST count=2 W=5 P=3: L=1, period 6; a start while busy is ignored
        tv.push_back(cf(3, 0, 5, 3, 2, 1, 0, 0, 4, 0, 0));
        tv.push_back(cy(8, 0, 12, 8, 0));
        tv.push_back(cy(0, 0, 12, 8, 0));
        tv.push_back(cy(8, 0, 12, 8, 0));
        tv.push_back(cy(0, 0, 12, 8, 0));
        tv.push_back(cy(0, 0, 12, 8, 0));
        tv.push_back(cy(0, 0, 4, 8, 0));
        for (int k = 0; k < 5; k++) tv.push_back(cy(0, 0, 12, 8, 0));
        tv.push_back(cy(0, 0, 4, 0, 8));
        tv.push_back(cy(0, 0, 4, 0, 0));
        // ch0 W=0: done one cycle after start, never busy
        tv.push_back(cf(0, 3, 0, 4, 1, 0, 0, 0, 4, 0, 0));
        tv.push_back(cy(1, 0, 4, 0, 1));
        tv.push_back(cy(0, 0, 4, 0, 0));
        // ch1 start and stop on the same edge: nothing happens
        tv.push_back(cy(2, 2, 4, 0, 0));
        tv.push_back(cy(0, 0, 4, 0, 0));
        // start with same-edge write uses old W=0; next start uses W=3; write mid-run ignored
        tv.push_back(cf(0, 0, 3, 4, 1, 0, 0, 1, 4, 0, 1));
        tv.push_back(cy(1, 0, 5, 1, 0));
        tv.push_back(cf(0, 0, 1, 4, 1, 0, 0, 0, 5, 1, 0));
        tv.push_back(cy(0, 0, 5, 1, 0));
        tv.push_back(cy(0, 0, 4, 0, 1));
        tv.push_back(cy(1, 0, 5, 1, 0));
        tv.push_back(cy(0, 0, 4, 0, 1));
        tv.push_back(cy(0, 0, 4, 0, 0));

        tick();
        tick();
        chk_out("reset", 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        tick();
        chk_out("post_reset", 4'h0, 4'h0, 4'h0);

        foreach (tv[j]) begin
            cfg_we     = tv[j].we;
            cfg_ch     = tv[j].ch;
            cfg_delay  = tv[j].d;
            cfg_width  = tv[j].w;
            cfg_period = tv[j].p;
            cfg_count  = tv[j].n;
            cfg_mode   = tv[j].m;
            cfg_init   = tv[j].ini;
            start      = tv[j].st;
            stop       = tv[j].sp;
            tick();
            chk_out($sformatf("row%0d", j), tv[j].ep, tv[j].eb, tv[j].ed);
        end
        cfg_we = 1'b0;
        start  = '0;
        stop   = '0;

`ifdef MULTI_PULSE_GEN_PCNT_EN
        chk("pulse_cnt", pulse_cnt, {8'd2, 8'd3, 8'd3, 8'd1});
`endif

        // asynchronous reset in the middle of a CONT run on ch2
        start = 4'h4;
        tick();
        start = '0;
        chk_out("cont_restart", 4'h0, 4'h4, 4'h0);
        tick();
        tick();
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 4'h0, 4'h0, 4'h0);
        #1 rst = 1'b0;
        tick();
        chk_out("after_rst", 4'h0, 4'h0, 4'h0);

        // reset config defaults: D=0 W=1 SINGLE init=0
        start = 4'h1;
        tick();
        start = '0;
        chk_out("dflt_hi", 4'h1, 4'h1, 4'h0);
        tick();
        chk_out("dflt_done", 4'h0, 4'h0, 4'h1);
        tick();
        chk_out("dflt_idle", 4'h0, 4'h0, 4'h0);
`ifdef MULTI_PULSE_GEN_PCNT_EN
        chk("pulse_cnt_after_rst", pulse_cnt, 32'h0000_0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
